// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM-side definitions: word width, ROM slot FSM states, offset width.
package jtframe_sdram_pkg;

  localparam int unsigned SDRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } slot_state_e;

  // Number of CPU address bits selecting a DW-wide unit inside one SDRAM word
  function automatic int unsigned offw(input int unsigned dw);
    return $clog2(SDRAM_DW / dw);
  endfunction

endpackage

// File: rtl/jtframe_romslot_if.sv
// ROM slot bus: CPU-side request/response and SDRAM arbiter handshake.
// slave = ROM slot side, master = CPU decoder / arbiter side.
interface jtframe_romslot_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 8
);
  import jtframe_sdram_pkg::*;

  localparam int unsigned OFFW = offw(DW);

  logic                rom_cs;
  logic [AW-1:0]       addr;
  logic                rom_ok;
  logic [DW-1:0]       dout;
  logic                sdram_req;
  logic [AW-OFFW-1:0]  sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [SDRAM_DW-1:0] din;

  modport slave (
    input  rom_cs, addr, sdram_ack, data_rdy, din,
    output rom_ok, dout, sdram_req, sdram_addr
  );

  modport master (
    output rom_cs, addr, sdram_ack, data_rdy, din,
    input  rom_ok, dout, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtframe_romslot_line.sv
// One cache line: tag, 32-bit data word and valid flag, with hit compare and word-select mux.
module jtframe_romslot_line
  import jtframe_sdram_pkg::*;
#(
  parameter  int unsigned AW   = 18,
  parameter  int unsigned DW   = 8,
  localparam int unsigned OFFW = offw(DW),
  localparam int unsigned TW   = AW - OFFW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr,
  input  logic                wr_valid,
  input  logic [TW-1:0]       wr_tag,
  input  logic [SDRAM_DW-1:0] wr_data,
  input  logic [TW-1:0]       lk_tag,
  input  logic [OFFW-1:0]     lk_off,
  output logic                hit,
  output logic [DW-1:0]       rd_data
);

  logic [TW-1:0]       tag_q,   tag_d;
  logic [SDRAM_DW-1:0] data_q,  data_d;
  logic                valid_q, valid_d;

  assign hit = valid_q && (tag_q == lk_tag);

  // Select the DW-wide unit addressed by the offset; lowest address sits in the low bits
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < SDRAM_DW / DW; i++) begin
      if (lk_off == OFFW'(i)) rd_data = data_q[i*DW +: DW];
    end
  end

  // Line update: fill loads tag/data, clear overrides the valid flag
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (wr) begin
      tag_d   = wr_tag;
      data_d  = wr_data;
      valid_d = wr_valid;
    end
    if (clr) valid_d = 1'b0;
  end

  // Line storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/jtframe_romslot.sv
// SDRAM-side responder for a CPU ROM port: one-word cache line, one SDRAM read per miss.
// Define JTFRAME_ROMSLOT_DUAL_EN for two lines with 1-bit LRU replacement.
module jtframe_romslot
  import jtframe_sdram_pkg::*;
#(
  parameter  int unsigned AW   = 18,
  parameter  int unsigned DW   = 8,
  localparam int unsigned OFFW = offw(DW),
  localparam int unsigned TW   = AW - OFFW
) (
  input logic              clk,
  input logic              rst_n,
  input logic              downloading,
  input logic              flush,
  jtframe_romslot_if.slave bus
);

`ifdef JTFRAME_ROMSLOT_DUAL_EN
  localparam int unsigned NL = 2;
`else
  localparam int unsigned NL = 1;
`endif

  logic [TW-1:0]   tag;
  logic [OFFW-1:0] off;
  logic [NL-1:0]   line_hit;
  logic [NL-1:0]   line_wr;
  logic [DW-1:0]   line_rd [NL];
  logic            hit;
  logic [DW-1:0]   hit_data;
  logic            clr;
  logic            fill;
  logic            fill_valid;
  logic            victim;

  slot_state_e   state_q,      state_d;
  logic          sdram_req_q,  sdram_req_d;
  logic [TW-1:0] sdram_addr_q, sdram_addr_d;
  logic          drop_q,       drop_d;
  logic          rom_ok_q,     rom_ok_d;
  logic [DW-1:0] dout_q,       dout_d;
`ifdef JTFRAME_ROMSLOT_DUAL_EN
  logic          lru_q,        lru_d;
`endif

  assign tag = bus.addr[AW-1:OFFW];
  assign off = bus.addr[OFFW-1:0];
  assign clr = flush | downloading;
  assign hit = |line_hit;

  for (genvar i = 0; i < NL; i++) begin : g_line
    assign line_wr[i] = fill && (victim == 1'(i));
    jtframe_romslot_line #(.AW(AW), .DW(DW)) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .wr       (line_wr[i]),
      .wr_valid (fill_valid),
      .wr_tag   (sdram_addr_q),
      .wr_data  (bus.din),
      .lk_tag   (tag),
      .lk_off   (off),
      .hit      (line_hit[i]),
      .rd_data  (line_rd[i])
    );
  end

  // Hit data mux; line 0 takes priority should both lines match
  always_comb begin
    hit_data = '0;
    for (int unsigned i = NL; i > 0; i--) begin
      if (line_hit[i-1]) hit_data = line_rd[i-1];
    end
  end

`ifdef JTFRAME_ROMSLOT_DUAL_EN
  assign victim = lru_q;

  // LRU pointer: a hit points at the other line; a fill points away from the line just written
  always_comb begin
    lru_d = lru_q;
    if (bus.rom_cs && hit) lru_d = line_hit[0];
    if (fill) lru_d = ~lru_q;
  end
`else
  assign victim = 1'b0;
`endif

  // Registered CPU response, re-evaluated every cycle against the current address
  always_comb begin
    rom_ok_d = bus.rom_cs & hit & ~clr;
    dout_d   = (bus.rom_cs && hit) ? hit_data : dout_q;
  end

  // Fetch FSM. drop_q remembers a flush/download seen during a fetch so the
  // fetch still completes but the filled line is left invalid.
  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    drop_d       = drop_q;
    fill         = 1'b0;
    fill_valid   = ~(drop_q | clr);
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (bus.rom_cs && !hit && !downloading) begin
          state_d      = ST_REQ;
          sdram_req_d  = 1'b1;
          sdram_addr_d = tag;
        end
      end
      ST_REQ: begin
        drop_d = drop_q | clr;
        if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          if (bus.data_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        drop_d = drop_q | clr;
        if (bus.data_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      drop_q       <= 1'b0;
      rom_ok_q     <= 1'b0;
      dout_q       <= '0;
`ifdef JTFRAME_ROMSLOT_DUAL_EN
      lru_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      drop_q       <= drop_d;
      rom_ok_q     <= rom_ok_d;
      dout_q       <= dout_d;
`ifdef JTFRAME_ROMSLOT_DUAL_EN
      lru_q        <= lru_d;
`endif
    end
  end

  assign bus.rom_ok     = rom_ok_q;
  assign bus.dout       = dout_q;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtframe_romslot.sv
// Self-checking bench for jtframe_romslot: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level cache model.
module tb_jtframe_romslot;
  import jtframe_sdram_pkg::*;

  localparam int unsigned AW   = 18;
  localparam int unsigned DW   = 8;
  localparam int unsigned OFFW = offw(DW);
  localparam int unsigned TW   = AW - OFFW;
`ifdef JTFRAME_ROMSLOT_DUAL_EN
  localparam int NLINES = 2;
`else
  localparam int NLINES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic downloading = 1'b0;
  logic flush = 1'b0;

  jtframe_romslot_if #(.AW(AW), .DW(DW)) bus ();

  jtframe_romslot #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .flush       (flush),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents seen through the arbiter
  function automatic logic [31:0] word_of(input logic [TW-1:0] t);
    if (t == TW'(1)) return 32'hDDCC_BBAA;
    return (32'(t) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [DW-1:0] pick(input logic [31:0] w, input logic [OFFW-1:0] o);
    logic [31:0] s;
    s = w >> (32'(o) * DW);
    return s[DW-1:0];
  endfunction

  // ---------------- reference model: cache contents + one outstanding fetch
  bit            mv [2];
  logic [TW-1:0] mt [2];
  int            mlru;
  bit            fetching, facked, fspoil;
  logic [TW-1:0] ftag;
  logic          e_ok, e_req;
  logic [DW-1:0] e_dout;
  logic [TW-1:0] e_saddr;
  int            m_reqs;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin mv[i] = 0; mt[i] = '0; end
    mlru = 0; fetching = 0; facked = 0; fspoil = 0; ftag = '0;
    e_ok = 0; e_req = 0; e_dout = '0; e_saddr = '0;
  endtask

  task automatic model_step();
    logic [TW-1:0]   t;
    logic [OFFW-1:0] o;
    int hl, nlru, v;
    bit spoil;
    t = bus.addr[AW-1:OFFW];
    o = bus.addr[OFFW-1:0];
    hl = -1;
    for (int i = NLINES - 1; i >= 0; i--) if (mv[i] && mt[i] == t) hl = i;
    nlru = mlru;
    e_ok = bus.rom_cs && (hl >= 0) && !downloading && !flush;
    if (bus.rom_cs && hl >= 0) begin
      e_dout = pick(word_of(t), o);
      nlru = 1 - hl;
    end
    if (!fetching) begin
      if (bus.rom_cs && hl < 0 && !downloading) begin
        fetching = 1; facked = 0; fspoil = 0; ftag = t;
        e_req = 1; e_saddr = t; m_reqs++;
      end
    end else begin
      spoil = fspoil || flush || downloading;
      fspoil = spoil;
      if (!facked && bus.sdram_ack) begin
        facked = 1; e_req = 0;
      end
      if (facked && bus.data_rdy) begin
        v = (NLINES == 2) ? mlru : 0;
        mt[v] = ftag; mv[v] = !spoil;
        nlru = 1 - v;
        fetching = 0;
      end
    end
    mlru = nlru;
    if (flush || downloading) for (int i = 0; i < 2; i++) mv[i] = 0;
  endtask

  // ---------------- arbiter stand-in
  int            arb_phase, arb_cnt, ack_dly, rdy_dly;
  bit            arb_rand;
  logic [TW-1:0] arb_tag;

  task automatic arb_reset();
    arb_phase = 0; arb_cnt = 0;
    bus.sdram_ack = 0; bus.data_rdy = 0; bus.din = '0;
  endtask

  task automatic arb_update();
    int rc;
    bus.sdram_ack = 0;
    bus.data_rdy  = 0;
    bus.din       = $urandom;
    if (arb_phase == 2) begin
      arb_cnt--;
      if (arb_cnt <= 0) begin
        bus.data_rdy = 1; bus.din = word_of(arb_tag); arb_phase = 0;
      end
    end else begin
      if (arb_phase == 0 && bus.sdram_req) begin
        arb_phase = 1;
        arb_tag   = bus.sdram_addr;
        arb_cnt   = arb_rand ? int'($urandom_range(0, 4)) : ack_dly;
      end
      if (arb_phase == 1) begin
        if (arb_cnt == 0) begin
          bus.sdram_ack = 1;
          rc = arb_rand ? int'($urandom_range(0, 4)) : rdy_dly;
          if (rc == 0) begin
            bus.data_rdy = 1; bus.din = word_of(arb_tag); arb_phase = 0;
          end else begin
            arb_phase = 2; arb_cnt = rc;
          end
        end else begin
          arb_cnt--;
        end
      end
    end
    // stray handshakes while nothing is outstanding must be ignored
    if (arb_rand && arb_phase == 0 && !bus.sdram_req) begin
      if ($urandom_range(0, 9) == 0) bus.sdram_ack = 1;
      if ($urandom_range(0, 9) == 0) bus.data_rdy = 1;
    end
  endtask

  // ---------------- cycle driver
  int   dut_reqs = 0;
  logic prev_req = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("rom_ok", bus.rom_ok, e_ok);
    if (e_ok) chk("dout", bus.dout, e_dout);
    chk("sdram_req", bus.sdram_req, e_req);
    chk("sdram_addr", bus.sdram_addr, e_saddr);
    if (bus.sdram_req && !prev_req) dut_reqs++;
    prev_req = bus.sdram_req;
    arb_update();
  endtask

  task automatic wait_req(input string tag, input logic [TW-1:0] exp_addr);
    int n = 0;
    while (!bus.sdram_req && n < 40) begin cycle(); n++; end
    chk(tag, bus.sdram_req, 1);
    chk({tag, "_addr"}, bus.sdram_addr, exp_addr);
  endtask

  task automatic wait_ok(input string tag);
    int n = 0;
    while (!bus.rom_ok && n < 60) begin cycle(); n++; end
    chk(tag, bus.rom_ok, 1);
  endtask

  task automatic wait_phase(input string tag, input int p);
    int n = 0;
    while (arb_phase != p && n < 40) begin cycle(); n++; end
    chk(tag, arb_phase, p);
  endtask

  task automatic access(input string tag, input logic [AW-1:0] a);
    bus.rom_cs = 1;
    bus.addr   = a;
    cycle();
    wait_ok(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bus.rom_cs = 0;
    bus.addr   = '0;
    arb_rand = 0; ack_dly = 2; rdy_dly = 3;
    arb_reset();
    model_reset();
    m_reqs = 0;

    // reset values
    #12;
    chk("rst_rom_ok", bus.rom_ok, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_req", bus.sdram_req, 0);
    chk("rst_saddr", bus.sdram_addr, 0);
    #1 rst_n = 1;

    // 1: cold miss on 0x00005
    bus.rom_cs = 1;
    bus.addr   = 18'h00005;
    cycle();
    chk("t1_req", bus.sdram_req, 1);
    chk("t1_saddr", bus.sdram_addr, 16'h0001);
    wait_ok("t1_ok");
    chk("t1_dout", bus.dout, 8'hBB);

    // 2: hit in the same word
    bus.addr = 18'h00006;
    cycle();
    chk("t2_ok", bus.rom_ok, 1);
    chk("t2_dout", bus.dout, 8'hCC);
    chk("t2_noreq", bus.sdram_req, 0);

    // 3: address moves while the fetch is in WAIT
    ack_dly = 1; rdy_dly = 4;
    bus.addr = 18'h00010;
    cycle();
    wait_phase("t3_wait", 2);
    bus.addr = 18'h00020;
    cycle();
    wait_req("t3_newreq", 16'h0008);
    wait_ok("t3_ok");

    // 4: flush while a hit is held, then flush during WAIT
    cycle();
    flush = 1;
    cycle();
    flush = 0;
    chk("t4_flush_ok", bus.rom_ok, 0);
    wait_req("t4_refetch", 16'h0008);
    wait_phase("t4_wait", 2);
    flush = 1;
    cycle();
    flush = 0;
    wait_phase("t4_filled", 0);
    wait_req("t4_refetch2", 16'h0008);
    wait_ok("t4_ok");

    // 5: reset while a request is outstanding
    ack_dly = 6;
    bus.addr = 18'h00040;
    cycle();
    wait_req("t5_req", 16'h0010);
    #2 rst_n = 0;
    #1;
    chk("t5_req_rst", bus.sdram_req, 0);
    chk("t5_ok_rst", bus.rom_ok, 0);
    chk("t5_saddr_rst", bus.sdram_addr, 0);
    chk("t5_dout_rst", bus.dout, 0);
    model_reset();
    arb_reset();
    prev_req = 0;
    #2 rst_n = 1;
    wait_req("t5_rereq", 16'h0010);
    wait_ok("t5_ok");

    // 6: alternate two tags, then evict with a third
    ack_dly = 1; rdy_dly = 2;
    bus.rom_cs = 0;
    flush = 1;
    cycle();
    flush = 0;
    cycle();
    base = dut_reqs;
    for (int k = 0; k < 3; k++) begin
      access("t6_acc1", 18'h00004);
      access("t6_acc2", 18'h00008);
    end
    chk("t6_alt_reqs", dut_reqs - base, (NLINES == 2) ? 2 : 6);
    base = dut_reqs;
    access("t6_acc3", 18'h0000C);
    chk("t6_third_reqs", dut_reqs - base, 1);
    base = dut_reqs;
    access("t6_keep", 18'h00008);
    chk("t6_keep_reqs", dut_reqs - base, (NLINES == 2) ? 0 : 1);
    base = dut_reqs;
    access("t6_evicted", 18'h00004);
    chk("t6_evicted_reqs", dut_reqs - base, 1);

    // randomized traffic
    arb_rand = 1;
    base = dut_reqs - m_reqs;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.rom_cs = ($urandom_range(0, 5) != 0);
        bus.addr   = {TW'($urandom_range(0, 5)), OFFW'($urandom_range(0, 3))};
      end
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) downloading = ~downloading;
      else if (downloading && $urandom_range(0, 7) == 0) downloading = 0;
      cycle();
    end
    flush = 0;
    downloading = 0;
    chk("rand_req_count", dut_reqs - m_reqs, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
